// File: rtl/ovc_allocator.sv
// Output-VC allocator for one output port.
// Arbitrates round-robin among waiting input VCs for a free output VC that has credit, records
// each OVC's owner, tracks downstream credits per OVC and frees an OVC when its tail departs.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   vc_req_i             per-input-VC request for an OVC on this port
//   vc_grant_o           registered one-hot grant pulse
//   grant_ovc_o          OVC index issued with vc_grant_o
//   flit_valid_i/ovc/tail  departing flit on this port
//   credit_valid_i/ovc   credit returned from downstream
//   ovc_free_o           per-OVC unowned flag
//   ovc_owner_o          per-OVC owner index, packed IN_W bits per OVC
//   credit_cnt_o         per-OVC credit count, packed CNT_W bits per OVC
//   err_o                sticky protocol-error flag
module ovc_allocator #(
  parameter int unsigned NUM_IN_VC  = 8,
  parameter int unsigned NUM_OVC    = 2,
  parameter int unsigned OVC_W      = 1,
  parameter int unsigned IN_W       = 3,
  parameter int unsigned CREDIT_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_IN_VC-1:0]     vc_req_i,
  output logic [NUM_IN_VC-1:0]     vc_grant_o,
  output logic [OVC_W-1:0]         grant_ovc_o,
  input  logic                     flit_valid_i,
  input  logic [OVC_W-1:0]         flit_ovc_i,
  input  logic                     flit_tail_i,
  input  logic                     credit_valid_i,
  input  logic [OVC_W-1:0]         credit_ovc_i,
  output logic [NUM_OVC-1:0]       ovc_free_o,
  output logic [NUM_OVC*IN_W-1:0]  ovc_owner_o,
  output logic [NUM_OVC*CNT_W-1:0] credit_cnt_o,
  output logic                     err_o
);

  typedef enum logic {StFree, StBusy} ovc_state_e;

  ovc_state_e           state_q  [NUM_OVC];
  ovc_state_e           state_d  [NUM_OVC];
  logic [IN_W-1:0]      owner_q  [NUM_OVC];
  logic [IN_W-1:0]      owner_d  [NUM_OVC];
  logic [CNT_W-1:0]     credit_q [NUM_OVC];
  logic [CNT_W-1:0]     credit_d [NUM_OVC];
  logic [NUM_IN_VC-1:0] grant_q, grant_d;
  logic [OVC_W-1:0]     grant_ovc_q, grant_ovc_d;
  logic [IN_W-1:0]      ptr_q, ptr_d;
  logic                 err_q, err_d;

  logic [NUM_IN_VC-1:0] owns_ovc;
  logic [NUM_IN_VC-1:0] eligible;
  logic                 tgt_found, win_found;
  logic [OVC_W-1:0]     tgt;
  logic [IN_W-1:0]      win;
  logic [IN_W-1:0]      idx;

  // Allocation decision, computed purely from registered state.
  always_comb begin
    owns_ovc = '0;
    for (int unsigned i = 0; i < NUM_IN_VC; i++) begin
      for (int unsigned k = 0; k < NUM_OVC; k++) begin
        if (state_q[k] == StBusy && owner_q[k] == IN_W'(i)) owns_ovc[i] = 1'b1;
      end
    end
    // Last cycle's winner must drop its request now; a stale one is ignored.
    eligible = vc_req_i & ~owns_ovc & ~grant_q;

    tgt_found = 1'b0;
    tgt       = '0;
    for (int unsigned k = 0; k < NUM_OVC; k++) begin
      if (!tgt_found && state_q[k] == StFree && credit_q[k] != '0) begin
        tgt_found = 1'b1;
        tgt       = OVC_W'(k);
      end
    end

    win_found = 1'b0;
    win       = '0;
    idx       = '0;
    for (int unsigned off = 0; off < NUM_IN_VC; off++) begin
      idx = IN_W'((32'(ptr_q) + off) % NUM_IN_VC);
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  // Next-state: grant, per-OVC ownership FSM, credit arithmetic, error flag.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    credit_d    = credit_q;
    err_d       = err_q;
    ptr_d       = ptr_q;
    grant_d     = '0;
    grant_ovc_d = '0;

    if (tgt_found && win_found) begin
      grant_d[win]   = 1'b1;
      grant_ovc_d    = tgt;
      ptr_d          = IN_W'((32'(win) + 32'd1) % NUM_IN_VC);
      state_d[tgt]   = StBusy;
      owner_d[tgt]   = win;
    end

    for (int unsigned k = 0; k < NUM_OVC; k++) begin
      logic dec, inc;
      dec = flit_valid_i && flit_ovc_i == OVC_W'(k);
      inc = credit_valid_i && credit_ovc_i == OVC_W'(k);

      // A granted OVC was free, so a tail can only ever hit a different, busy OVC.
      if (dec && state_q[k] == StFree) err_d = 1'b1;
      if (dec && flit_tail_i && state_q[k] == StBusy) state_d[k] = StFree;

      if (dec && !inc) begin
        if (credit_q[k] == '0) err_d = 1'b1;
        else                   credit_d[k] = credit_q[k] - CNT_W'(1);
      end else if (inc && !dec) begin
        if (credit_q[k] == CNT_W'(CREDIT_MAX)) err_d = 1'b1;
        else                                   credit_d[k] = credit_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NUM_OVC; k++) begin
        state_q[k]  <= StFree;
        owner_q[k]  <= '0;
        credit_q[k] <= CNT_W'(CREDIT_MAX);
      end
      grant_q     <= '0;
      grant_ovc_q <= '0;
      ptr_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      credit_q    <= credit_d;
      grant_q     <= grant_d;
      grant_ovc_q <= grant_ovc_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    ovc_free_o   = '0;
    ovc_owner_o  = '0;
    credit_cnt_o = '0;
    for (int unsigned k = 0; k < NUM_OVC; k++) begin
      ovc_free_o[k]                 = state_q[k] == StFree;
      ovc_owner_o[k*IN_W +: IN_W]   = owner_q[k];
      credit_cnt_o[k*CNT_W +: CNT_W] = credit_q[k];
    end
  end

  assign vc_grant_o  = grant_q;
  assign grant_ovc_o = grant_ovc_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ovc_allocator.sv
// Directed bench for ovc_allocator: a vector table walked edge by edge plus short hand-written
// sequences for asynchronous mid-packet reset, round-robin wrap and single-flit packets.
module tb_ovc_allocator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] vc_req;
  logic [7:0] vc_grant;
  logic       grant_ovc;
  logic       flit_valid, flit_ovc, flit_tail;
  logic       credit_valid, credit_ovc;
  logic [1:0] ovc_free;
  logic [5:0] ovc_owner;
  logic [5:0] credit_cnt;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ovc_allocator dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .vc_req_i       (vc_req),
    .vc_grant_o     (vc_grant),
    .grant_ovc_o    (grant_ovc),
    .flit_valid_i   (flit_valid),
    .flit_ovc_i     (flit_ovc),
    .flit_tail_i    (flit_tail),
    .credit_valid_i (credit_valid),
    .credit_ovc_i   (credit_ovc),
    .ovc_free_o     (ovc_free),
    .ovc_owner_o    (ovc_owner),
    .credit_cnt_o   (credit_cnt),
    .err_o          (err)
  );

  typedef struct {
    logic [7:0] req;
    logic       fv;
    logic       fovc;
    logic       ft;
    logic       cv;
    logic       covc;
    logic [7:0] grant;
    logic       govc;
    logic [1:0] free;
    logic [2:0] own0;
    logic [2:0] own1;
    logic [2:0] c0;
    logic [2:0] c1;
    logic       err;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 ns after the next rising edge.
  task automatic step(input logic [7:0] req, input logic fv, input logic fovc, input logic ft,
                      input logic cv, input logic covc);
    @(negedge clk);
    vc_req       = req;
    flit_valid   = fv;
    flit_ovc     = fovc;
    flit_tail    = ft;
    credit_valid = cv;
    credit_ovc   = covc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_grant"}, 32'(vc_grant), 32'h0);
    chk({tag, "_free"}, 32'(ovc_free), 32'h3);
    chk({tag, "_owner"}, 32'(ovc_owner), 32'h0);
    chk({tag, "_credit"}, 32'(credit_cnt), 32'(6'o44));
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    // VC2 then VC5 take both OVCs; credit drain/return; tail frees OVC1 and VC0 gets it next edge.
    //            req    fv    fo    ft    cv    co    grant  go    free   o0    o1    c0    c1    err
    vecs[0]  = '{8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04, 1'b0, 2'b10, 3'd2, 3'd0, 3'd4, 3'd4, 1'b0};
    vecs[1]  = '{8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 2'b00, 3'd2, 3'd5, 3'd4, 3'd4, 1'b0};
    vecs[2]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'd2, 3'd5, 3'd4, 3'd3, 1'b0};
    vecs[3]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'd2, 3'd5, 3'd4, 3'd2, 1'b0};
    vecs[4]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 2'b00, 3'd2, 3'd5, 3'd4, 3'd2, 1'b0};
    vecs[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 2'b00, 3'd2, 3'd5, 3'd4, 3'd3, 1'b0};
    vecs[6]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'd2, 3'd5, 3'd3, 3'd3, 1'b0};
    vecs[7]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'd2, 3'd5, 3'd2, 3'd3, 1'b0};
    vecs[8]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'd2, 3'd5, 3'd1, 3'd3, 1'b0};
    vecs[9]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'd2, 3'd5, 3'd0, 3'd3, 1'b0};
    vecs[10] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'd2, 3'd5, 3'd0, 3'd3, 1'b1};
    vecs[11] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 3'd2, 3'd5, 3'd1, 3'd3, 1'b1};
    vecs[12] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'd2, 3'd5, 3'd1, 3'd3, 1'b1};
    vecs[13] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b10, 3'd2, 3'd0, 3'd1, 3'd2, 1'b1};
    vecs[14] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 2'b00, 3'd2, 3'd0, 3'd1, 3'd2, 1'b1};
    vecs[15] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'd2, 3'd0, 3'd1, 3'd2, 1'b1};

    rst_n        = 1'b0;
    vc_req       = '0;
    flit_valid   = 1'b0;
    flit_ovc     = 1'b0;
    flit_tail    = 1'b0;
    credit_valid = 1'b0;
    credit_ovc   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].req, vecs[i].fv, vecs[i].fovc, vecs[i].ft, vecs[i].cv, vecs[i].covc);
      chk($sformatf("v%0d_grant", i), 32'(vc_grant), 32'(vecs[i].grant));
      if (vecs[i].grant != 8'h00) chk($sformatf("v%0d_govc", i), 32'(grant_ovc), 32'(vecs[i].govc));
      chk($sformatf("v%0d_free", i), 32'(ovc_free), 32'(vecs[i].free));
      if (!vecs[i].free[0]) chk($sformatf("v%0d_own0", i), 32'(ovc_owner[2:0]), 32'(vecs[i].own0));
      if (!vecs[i].free[1]) chk($sformatf("v%0d_own1", i), 32'(ovc_owner[5:3]), 32'(vecs[i].own1));
      chk($sformatf("v%0d_c0", i), 32'(credit_cnt[2:0]), 32'(vecs[i].c0));
      chk($sformatf("v%0d_c1", i), 32'(credit_cnt[5:3]), 32'(vecs[i].c1));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
    end

    // Asynchronous reset mid-packet: both OVCs busy and err set; outputs must clear without a clock.
    @(negedge clk);
    vc_req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // Pointer back at 0: VC0 then VC7 win on consecutive edges, then nothing is free.
    step(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rr_g0", 32'(vc_grant), 32'h01);
    chk("rr_g0_ovc", 32'(grant_ovc), 32'h0);
    chk("rr_g0_free", 32'(ovc_free), 32'h2);
    step(8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rr_g1", 32'(vc_grant), 32'h80);
    chk("rr_g1_ovc", 32'(grant_ovc), 32'h1);
    chk("rr_g1_own1", 32'(ovc_owner[5:3]), 32'h7);
    step(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rr_nofree", 32'(vc_grant), 32'h0);

    // Single-flit packet on OVC0: head+tail frees it, credit drops; VC1 gets OVC0 one edge later.
    step(8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sf_grant", 32'(vc_grant), 32'h0);
    chk("sf_free", 32'(ovc_free), 32'h1);
    chk("sf_c0", 32'(credit_cnt[2:0]), 32'h3);
    chk("sf_err", 32'(err), 32'h0);
    step(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sf_regrant", 32'(vc_grant), 32'h02);
    chk("sf_regrant_ovc", 32'(grant_ovc), 32'h0);
    chk("sf_regrant_own", 32'(ovc_owner[2:0]), 32'h1);

    // Flit on a free OVC: error, credit still consumed, OVC stays free.
    step(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("freeflit_free", 32'(ovc_free), 32'h1);
    chk("freeflit_c0", 32'(credit_cnt[2:0]), 32'h1);
    chk("freeflit_err", 32'(err), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
